// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings used by the
// interface, the top level and the testbench.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L    = 2'b00,
        MODE_ROT_R    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_BAR      = 2'b11
    } mode_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between board-level control logic (master) and the
// LED pattern engine (slave).
interface led_pattern_gen_if #(
    parameter int LED_NUM = 4
);
    import led_pkg::*;

    mode_t              mode;
    logic               run_en;
    logic [1:0]         speed;
    logic [LED_NUM-1:0] led_out;
    logic               step_pulse;
    logic               wrap_pulse;

    modport master (
        output mode, run_en, speed,
        input  led_out, step_pulse, wrap_pulse
    );

    modport slave (
        input  mode, run_en, speed,
        output led_out, step_pulse, wrap_pulse
    );

endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// Base-tick prescaler: counts 0..CNT_MAX while enabled; the count freezes when
// run_en is low and restarts from zero on clr.
module led_tick_gen #(
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run_en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run_en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = run_en && (cnt == CNT_MAX);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine: prescaled base tick, speed divider, and a
// pattern register that rotates, ping-pongs or fills depending on mode.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int               LED_NUM    = 4,
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] CNT_MAX    = 25'd24_999_999,
    parameter bit               ACTIVE_LOW = 1'b1
) (
    input logic              sys_clk,
    input logic              sys_rst_n,
    led_pattern_gen_if.slave bus
);

    localparam logic [LED_NUM-1:0] PAT_LSB = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};

    function automatic logic [LED_NUM-1:0] start_val(input mode_t m);
        return (m == MODE_ROT_R) ? PAT_MSB : PAT_LSB;
    endfunction

    mode_t              mode_q;
    logic               dir_up;
    logic [1:0]         div;
    logic [LED_NUM-1:0] pattern;
    logic [LED_NUM-1:0] nxt_pattern;
    logic               nxt_dir_up;
    logic               tick;
    logic               mode_chg;
    logic               step_pulse_q;
    logic               wrap_pulse_q;

    assign mode_chg = (bus.mode != mode_q);

    led_tick_gen #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run_en    (bus.run_en),
        .clr       (mode_chg),
        .tick      (tick)
    );

    // Any pattern outside the current mode's sequence falls back to that mode's start value.
    always_comb begin
        nxt_pattern = pattern;
        nxt_dir_up  = dir_up;
        case (mode_q)
            MODE_ROT_L: begin
                nxt_pattern = $onehot(pattern) ? {pattern[LED_NUM-2:0], pattern[LED_NUM-1]} : PAT_LSB;
            end
            MODE_ROT_R: begin
                nxt_pattern = $onehot(pattern) ? {pattern[0], pattern[LED_NUM-1:1]} : PAT_MSB;
            end
            MODE_PINGPONG: begin
                if (!$onehot(pattern) || (dir_up && pattern[LED_NUM-1]) || (!dir_up && pattern[0])) begin
                    nxt_pattern = PAT_LSB;
                    nxt_dir_up  = 1'b1;
                end else if (dir_up) begin
                    nxt_pattern = pattern << 1;
                    nxt_dir_up  = !nxt_pattern[LED_NUM-1];
                end else begin
                    nxt_pattern = pattern >> 1;
                    nxt_dir_up  = nxt_pattern[0];
                end
            end
            default: begin
                if ((pattern != '0) && ((pattern & (pattern + LED_NUM'(1))) == '0))
                    nxt_pattern = (&pattern) ? PAT_LSB : {pattern[LED_NUM-2:0], 1'b1};
                else
                    nxt_pattern = PAT_LSB;
            end
        endcase
    end

    // A mode change wins over a coincident step and suppresses both pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q       <= MODE_ROT_L;
            dir_up       <= 1'b1;
            div          <= '0;
            pattern      <= PAT_LSB;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            mode_q       <= bus.mode;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            if (mode_chg) begin
                pattern <= start_val(bus.mode);
                dir_up  <= 1'b1;
                div     <= '0;
            end else if (tick) begin
                if (div >= bus.speed) begin
                    div          <= '0;
                    pattern      <= nxt_pattern;
                    dir_up       <= nxt_dir_up;
                    step_pulse_q <= 1'b1;
                    wrap_pulse_q <= (nxt_pattern == start_val(mode_q));
                end else begin
                    div <= div + 2'd1;
                end
            end
        end
    end

    assign bus.led_out    = ACTIVE_LOW ? ~pattern : pattern;
    assign bus.step_pulse = step_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;

endmodule
